mac_pipeline: RTL and testbench

//  Parametrised 3-stage unsigned multiply-add pipeline: out = a*b + c (mode 0), or running

---
 rtl/mac_pipeline.sv | 139 +++++++++++++
 tb/tb_mac_pipeline.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mac_pipeline.sv
// mac_pipeline
//   Three-stage unsigned multiply-add pipeline.
//     mode 0 : result = a*b + c
//     mode 1 : result = acc += a*b  (acc_clr restarts the running sum at a*b)
//   Results are truncated to OUT_W bits. ovf flags a result that does not fit.
//   With SATURATE != 0, an overflowing result is clamped to all-ones.
//   If the output is held (out_valid & !out_ready), every stage, the
//   accumulator and the outputs hold as well.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       input beat present
//   in_ready   out  1       beat accepted this cycle (combinational from out_ready)
//   a, b       in   DATA_W  multiplicand / multiplier
//   c          in   DATA_W  addend, mode 0 only
//   mode       in   1       0: a*b+c, 1: accumulate a*b
//   acc_clr    in   1       mode 1 only: restart accumulation
//   out_valid  out  1       result beat present
//   out_ready  in   1       downstream accepts result
//   data_out   out  OUT_W   result
//   ovf        out  1       result exceeded OUT_W bits
module mac_pipeline #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              mode,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 4;

  logic pipe_en;

  // stage 1
  logic              s1_valid;
  logic [PROD_W-1:0] s1_prod;
  logic [DATA_W-1:0] s1_c;
  logic              s1_mode;
  logic              s1_clr;

  // stage 2
  logic              s2_valid;
  logic [SUM_W-1:0]  s2_sum;
  logic [SUM_W-1:0]  acc;

  logic [PROD_W-1:0] prod_nxt;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  c_ext;
  logic [SUM_W-1:0]  acc_base;
  logic [SUM_W-1:0]  acc_nxt;
  logic [SUM_W-1:0]  sum_nxt;
  logic              ovf_nxt;
  logic [OUT_W-1:0]  data_nxt;

  // Backpressure is global: a held output freezes the whole pipeline, bubbles included.
  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;

  assign prod_nxt = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  assign prod_ext = {{(SUM_W-PROD_W){1'b0}}, s1_prod};
  assign c_ext    = {{(SUM_W-DATA_W){1'b0}}, s1_c};
  // After reset acc is 0, so the first mode-1 beat also starts from zero.
  assign acc_base = s1_clr ? '0 : acc;
  assign acc_nxt  = acc_base + prod_ext;
  assign sum_nxt  = s1_mode ? acc_nxt : (prod_ext + c_ext);

  // Overflow is taken from the upper bits of the stage-2 sum. When OUT_W
  // covers the full sum width, no upper bits exist and the flag stays 0.
  generate
    if (OUT_W < SUM_W) begin : g_ovf_hi
      assign ovf_nxt = |s2_sum[SUM_W-1:OUT_W];
    end else begin : g_ovf_none
      assign ovf_nxt = 1'b0;
    end
  endgenerate

  assign data_nxt = ((SATURATE != 0) && ovf_nxt) ? {OUT_W{1'b1}} : s2_sum[OUT_W-1:0];

  // S1: register product and sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_c     <= '0;
      s1_mode  <= 1'b0;
      s1_clr   <= 1'b0;
    end else if (pipe_en) begin
      s1_valid <= in_valid;
      s1_prod  <= prod_nxt;
      s1_c     <= c;
      s1_mode  <= mode;
      s1_clr   <= acc_clr;
    end
  end

  // S2: add / accumulate. Only valid mode-1 beats touch acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      acc      <= '0;
    end else if (pipe_en) begin
      s2_valid <= s1_valid;
      s2_sum   <= sum_nxt;
      if (s1_valid && s1_mode) begin
        acc <= acc_nxt;
      end
    end
  end

  // S3: truncate / saturate into output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      ovf       <= 1'b0;
    end else if (pipe_en) begin
      out_valid <= s2_valid;
      data_out  <= data_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_pipeline.sv
// tb_mac_pipeline
//   Directed bench for mac_pipeline. Two instances share the stimulus: u_wrap
//   (SATURATE=0) and u_sat (SATURATE=1). Both have the same handshake and
//   timing, so the saturating outputs are only checked in the overflow case.
module tb_mac_pipeline;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b, c;
  logic       mode, acc_clr;
  logic       out_ready;

  logic       in_ready, out_valid, ovf;
  logic [7:0] data_out;
  logic       in_ready_s, out_valid_s, ovf_s;
  logic [7:0] data_out_s;

  int checks = 0;
  int errors = 0;
  int sent, rcv;
  int exp4 [8];

  mac_pipeline #(.DATA_W(8), .OUT_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .ovf(ovf)
  );

  mac_pipeline #(.DATA_W(8), .OUT_W(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s), .out_ready(out_ready), .data_out(data_out_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                       input logic vm, input logic vclr);
    a        = va;
    b        = vb;
    c        = vc;
    mode     = vm;
    acc_clr  = vclr;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int exp_data, input logic exp_ovf);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  data_out, exp_data);
    chk({tag, "_ovf"},   ovf, exp_ovf);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a = 8'd0; b = 8'd0; c = 8'd0;
    mode      = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out",  data_out, 0);
    chk("rst_ovf",       ovf, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_in_ready",  in_ready, 1);

    // T1: 3*4+5 = 17, three edges after presentation
    drive(8'd3, 8'd4, 8'd5, 1'b0, 1'b0);
    tick(); idle();
    tick();
    chk("t1_not_early", out_valid, 0);
    tick();
    chk_out("t1", 17, 1'b0);
    tick();
    chk("t1_single_beat", out_valid, 0);

    // T2: 255*255+255 = 0xFF00
    drive(8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    tick(); idle();
    tick(); tick();
    chk_out("t2_wrap", 0, 1'b1);
    chk("t2_sat_valid", out_valid_s, 1);
    chk("t2_sat_data",  data_out_s, 255);
    chk("t2_sat_ovf",   ovf_s, 1);
    tick();

    // T3: accumulate back-to-back: 6, 26, 27, then restart -> 7
    drive(8'd2, 8'd3, 8'd0, 1'b1, 1'b1); tick();
    drive(8'd4, 8'd5, 8'd0, 1'b1, 1'b0); tick();
    drive(8'd1, 8'd1, 8'd0, 1'b1, 1'b0); tick();
    drive(8'd7, 8'd1, 8'd0, 1'b1, 1'b1);
    chk_out("t3_b0", 6, 1'b0);
    tick(); idle();
    chk_out("t3_b1", 26, 1'b0);
    tick();
    chk_out("t3_b2", 27, 1'b0);
    tick();
    chk_out("t3_b3", 7, 1'b0);
    tick();

    // T6: mode-0 beat between mode-1 beats leaves acc alone
    drive(8'd2, 8'd2, 8'd0, 1'b1, 1'b1); tick();
    drive(8'd10, 8'd10, 8'd1, 1'b0, 1'b1); tick();
    drive(8'd1, 8'd1, 8'd0, 1'b1, 1'b0); tick();
    idle();
    chk_out("t6_b0", 4, 1'b0);
    tick();
    chk_out("t6_b1", 101, 1'b0);
    tick();
    chk_out("t6_b2", 5, 1'b0);
    tick(); tick();

    // T4: 8 beats, output stalled for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) exp4[i] = 3 * i + 2;
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 8) drive(8'(sent + 1), 8'd2, 8'(sent), 1'b0, 1'b0);
      else idle();
      #1;
      if (out_valid && !out_ready && rcv < 8) begin
        chk("t4_stall_in_ready", in_ready, 0);
        chk("t4_stall_hold", data_out, exp4[rcv]);
      end
      if (out_valid && out_ready && rcv < 8) begin
        chk("t4_stream_data", data_out, exp4[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    idle();
    out_ready = 1'b1;
    chk("t4_sent", sent, 8);
    chk("t4_received", rcv, 8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_dup", out_valid, 0);
      tick();
    end

    // T5: reset with beats in flight and acc = 26
    drive(8'd2, 8'd3, 8'd0, 1'b1, 1'b1); tick();
    drive(8'd4, 8'd5, 8'd0, 1'b1, 1'b0); tick();
    drive(8'd1, 8'd1, 8'd0, 1'b0, 1'b0); tick();
    chk_out("t5_pre_a", 6, 1'b0);
    drive(8'd1, 8'd1, 8'd0, 1'b0, 1'b0); tick();
    idle();
    chk_out("t5_pre_b", 26, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_data_out",  data_out, 0);
    chk("t5_rst_in_ready",  in_ready, 1);
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_partial", out_valid, 0);
    end
    drive(8'd3, 8'd3, 8'd0, 1'b1, 1'b0);
    tick(); idle();
    tick(); tick();
    chk_out("t5_after", 9, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
